dekatron_counter: RTL and testbench

- Parametrised cycle-level model of a multi-cathode glow-transfer counter tube: a single glow walks a ring of POSITIONS main cathodes, with two guide cathodes between each adjacent pair.
- Next generation of the fixed 10-position tube model. Adds:
  - generic position count;
  - explicit two-phase transfer FSM with direction memory;
  - configurable settle time;
  - carry/borrow pulses for chaining digits;
  - binary position readout and load validation.
- Sits at the bottom of the counter/register datapath; one instance per decimal digit.

---
 rtl/dekatron_pkg.sv | 21 ++
 rtl/dekatron_onehot_chk.sv | 25 ++
 rtl/dekatron_counter.sv | 142 ++++++++++++++
 tb/tb_dekatron_counter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dekatron_pkg.sv
// Shared types and ring-geometry constants for the glow-transfer counter tube model.
package dekatron_pkg;

    typedef enum logic [1:0] {
        ST_MAIN   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

    // Each position owns three consecutive ring bits: main, then its two guides.
    localparam int CATHODES_PER_POS = 3;
    localparam int MAIN_OFS         = 0;
    localparam int G1_OFS           = 1;
    localparam int G2_OFS           = 2;

endpackage

// File: rtl/dekatron_onehot_chk.sv
// One-hot classifier and encoder for a POSITIONS-wide vector.
module dekatron_onehot_chk #(
    parameter int POSITIONS = 10,
    parameter int IDX_W     = $clog2(POSITIONS)
) (
    input  logic [POSITIONS-1:0] vec,
    output logic                 is_zero,
    output logic                 is_onehot,
    output logic [IDX_W-1:0]     index
);

    // OR of set-bit indices: exact whenever vec is one-hot.
    always_comb begin
        index = '0;
        for (int i = 0; i < POSITIONS; i++) begin
            if (vec[i]) begin
                index = index | IDX_W'(i);
            end
        end
    end

    assign is_zero   = (vec == '0);
    assign is_onehot = !is_zero && ((vec & (vec - 1'b1)) == '0);

endmodule

// File: rtl/dekatron_counter.sv
// Cycle-level glow-transfer counter tube: one glow walking a ring of main and guide
// cathodes, with two-phase transfer, settle delay, carry/borrow and one-hot load.
module dekatron_counter
    import dekatron_pkg::*;
#(
    parameter int POSITIONS     = 10,
    parameter int SETTLE_CYCLES = 1,
    parameter int POS_W         = $clog2(POSITIONS)
) (
    input  logic                 hsClk,
    input  logic                 Rst_n,
    input  logic                 PulseRight,
    input  logic                 PulseLeft,
    input  logic [POSITIONS-1:0] In,
    output logic [POSITIONS-1:0] Out,
    output logic [POS_W-1:0]     Position,
    output logic                 Busy,
    output logic                 CarryOut,
    output logic                 BorrowOut,
    output logic                 LoadErr
);

    localparam int RING     = CATHODES_PER_POS * POSITIONS;
    localparam int CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam int LAST_G1  = CATHODES_PER_POS * (POSITIONS - 1) + G1_OFS;
    localparam int LAST_G2  = CATHODES_PER_POS * (POSITIONS - 1) + G2_OFS;

    state_t            state;
    dir_t              dir;
    logic [RING-1:0]   ring;
    logic [CNT_W-1:0]  cnt;

    logic [RING-1:0]      ring_up, ring_dn, ring_dir, ring_load;
    logic [POSITIONS-1:0] dir_mains;
    logic                 in_zero, in_onehot;
    logic [POS_W-1:0]     in_idx;
    logic                 land_zero, land_onehot;
    logic [POS_W-1:0]     land_idx;
    logic                 unused_land;

    assign ring_up  = {ring[RING-2:0], ring[RING-1]};
    assign ring_dn  = {ring[0], ring[RING-1:1]};
    assign ring_dir = (dir == DIR_RIGHT) ? ring_up : ring_dn;

    always_comb begin
        dir_mains = '0;
        ring_load = '0;
        Out       = '0;
        for (int p = 0; p < POSITIONS; p++) begin
            dir_mains[p]                             = ring_dir[CATHODES_PER_POS*p + MAIN_OFS];
            ring_load[CATHODES_PER_POS*p + MAIN_OFS] = In[p];
            Out[p]                                   = ring[CATHODES_PER_POS*p + MAIN_OFS];
        end
    end

    dekatron_onehot_chk #(.POSITIONS(POSITIONS), .IDX_W(POS_W)) u_load_chk (
        .vec       (In),
        .is_zero   (in_zero),
        .is_onehot (in_onehot),
        .index     (in_idx)
    );

    dekatron_onehot_chk #(.POSITIONS(POSITIONS), .IDX_W(POS_W)) u_land_chk (
        .vec       (dir_mains),
        .is_zero   (land_zero),
        .is_onehot (land_onehot),
        .index     (land_idx)
    );

    assign unused_land = land_zero;

    // The settle counter is loaded with the full SETTLE_CYCLES so the landing
    // happens SETTLE_CYCLES+1 cycles after the release is sampled.
    always_ff @(posedge hsClk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_MAIN;
            dir       <= DIR_RIGHT;
            ring      <= RING'(1);
            cnt       <= '0;
            Position  <= '0;
            Busy      <= 1'b0;
            CarryOut  <= 1'b0;
            BorrowOut <= 1'b0;
            LoadErr   <= 1'b0;
        end else begin
            CarryOut  <= 1'b0;
            BorrowOut <= 1'b0;
            LoadErr   <= 1'b0;
            if (in_onehot) begin
                ring     <= ring_load;
                state    <= ST_MAIN;
                cnt      <= '0;
                Busy     <= 1'b0;
                Position <= in_idx;
            end else if (!in_zero) begin
                LoadErr <= 1'b1;
            end else begin
                case (state)
                    ST_MAIN: begin
                        if (PulseRight && !PulseLeft) begin
                            ring  <= ring_up;
                            dir   <= DIR_RIGHT;
                            state <= ST_HOLD;
                            Busy  <= 1'b1;
                        end else if (PulseLeft && !PulseRight) begin
                            ring  <= ring_dn;
                            dir   <= DIR_LEFT;
                            state <= ST_HOLD;
                            Busy  <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (!((dir == DIR_RIGHT) ? PulseRight : PulseLeft)) begin
                            ring  <= ring_dir;
                            cnt   <= CNT_W'(SETTLE_CYCLES);
                            state <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt == '0) begin
                            ring      <= ring_dir;
                            state     <= ST_MAIN;
                            Busy      <= 1'b0;
                            CarryOut  <= (dir == DIR_RIGHT) && ring[LAST_G2];
                            BorrowOut <= (dir == DIR_LEFT) && ring[LAST_G1];
                            if (land_onehot) begin
                                Position <= land_idx;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_MAIN;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dekatron_counter.sv
// Directed scoreboard bench for dekatron_counter across three parameter sets.
module tb_dekatron_counter;

    logic clk;
    logic rst_n;

    logic        a_right, a_left, a_busy, a_carry, a_borrow, a_lerr;
    logic [9:0]  a_in, a_out;
    logic [3:0]  a_pos;

    logic        b_right, b_left, b_busy, b_carry, b_borrow, b_lerr;
    logic [9:0]  b_in, b_out;
    logic [3:0]  b_pos;

    logic        c_right, c_left, c_busy, c_carry, c_borrow, c_lerr;
    logic [11:0] c_in, c_out;
    logic [3:0]  c_pos;

    int errors = 0;
    int checks = 0;
    int carry_cnt = 0;
    int borrow_cnt = 0;

    string       q_tag[$];
    logic [31:0] q_exp[$];

    dekatron_counter #(.POSITIONS(10), .SETTLE_CYCLES(1)) u_a (
        .hsClk(clk), .Rst_n(rst_n), .PulseRight(a_right), .PulseLeft(a_left),
        .In(a_in), .Out(a_out), .Position(a_pos), .Busy(a_busy),
        .CarryOut(a_carry), .BorrowOut(a_borrow), .LoadErr(a_lerr)
    );

    dekatron_counter #(.POSITIONS(10), .SETTLE_CYCLES(3)) u_b (
        .hsClk(clk), .Rst_n(rst_n), .PulseRight(b_right), .PulseLeft(b_left),
        .In(b_in), .Out(b_out), .Position(b_pos), .Busy(b_busy),
        .CarryOut(b_carry), .BorrowOut(b_borrow), .LoadErr(b_lerr)
    );

    dekatron_counter #(.POSITIONS(12), .SETTLE_CYCLES(2)) u_c (
        .hsClk(clk), .Rst_n(rst_n), .PulseRight(c_right), .PulseLeft(c_left),
        .In(c_in), .Out(c_out), .Position(c_pos), .Busy(c_busy),
        .CarryOut(c_carry), .BorrowOut(c_borrow), .LoadErr(c_lerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        q_tag.push_back(tag);
        q_exp.push_back(v);
    endtask

    task automatic observe(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        checks++;
        if (q_exp.size() == 0) begin
            errors++;
            $error("FAIL sb_underflow: observed %0h with no expectation queued", obs);
        end else begin
            tag = q_tag.pop_front();
            exp = q_exp.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_right = 1'b0; a_left = 1'b0; a_in = '0;
        b_right = 1'b0; b_left = 1'b0; b_in = '0;
        c_right = 1'b0; c_left = 1'b0; c_in = '0;
        #12;

        // Reset state
        expect_val("rst_a_out", 32'h1);   observe(32'(a_out));
        expect_val("rst_a_pos", 32'h0);   observe(32'(a_pos));
        expect_val("rst_a_busy", 32'h0);  observe(32'(a_busy));
        expect_val("rst_a_carry", 32'h0); observe(32'(a_carry));
        expect_val("rst_a_borrow", 32'h0); observe(32'(a_borrow));
        expect_val("rst_a_lerr", 32'h0);  observe(32'(a_lerr));
        expect_val("rst_c_out", 32'h1);   observe(32'(c_out));
        rst_n = 1'b1;
        cyc();

        // Asynchronous reset in the middle of a settle (SETTLE_CYCLES=3)
        expect_val("t1_busy_settle", 32'h1);
        expect_val("t1_out_settle", 32'h0);
        b_right = 1'b1; cyc();
        b_right = 1'b0; cyc();
        cyc();
        observe(32'(b_busy));
        observe(32'(b_out));
        #2;
        expect_val("t1_out_async", 32'h1);
        expect_val("t1_pos_async", 32'h0);
        expect_val("t1_busy_async", 32'h0);
        rst_n = 1'b0;
        #1;
        observe(32'(b_out));
        observe(32'(b_pos));
        observe(32'(b_busy));
        rst_n = 1'b1;
        cyc();

        // Right step with pulse held two cycles (SETTLE_CYCLES=1)
        expect_val("t2_busy_e1", 32'h1); expect_val("t2_out_e1", 32'h0);
        a_right = 1'b1; cyc();
        observe(32'(a_busy)); observe(32'(a_out));
        expect_val("t2_busy_e2", 32'h1);
        cyc(); observe(32'(a_busy));
        a_right = 1'b0;
        expect_val("t2_busy_e3", 32'h1); expect_val("t2_pos_hold", 32'h0);
        cyc(); observe(32'(a_busy)); observe(32'(a_pos));
        expect_val("t2_busy_e4", 32'h1); expect_val("t2_out_e4", 32'h0);
        cyc(); observe(32'(a_busy)); observe(32'(a_out));
        expect_val("t2_busy_land", 32'h0); expect_val("t2_out_land", 32'h2);
        expect_val("t2_pos_land", 32'h1);
        cyc(); observe(32'(a_busy)); observe(32'(a_out)); observe(32'(a_pos));

        // Load 9 then wrap right: carry; then wrap left: borrow
        expect_val("t3_load_out", 32'h200); expect_val("t3_load_pos", 32'h9);
        a_in = 10'b1000000000; cyc(); a_in = '0;
        observe(32'(a_out)); observe(32'(a_pos));
        expect_val("t3_carry_out", 32'h1); expect_val("t3_carry_pos", 32'h0);
        expect_val("t3_carry", 32'h1); expect_val("t3_carry_bor", 32'h0);
        a_right = 1'b1; cyc(); a_right = 1'b0;
        repeat (3) cyc();
        observe(32'(a_out)); observe(32'(a_pos)); observe(32'(a_carry)); observe(32'(a_borrow));
        expect_val("t3_carry_drop", 32'h0);
        cyc(); observe(32'(a_carry));
        expect_val("t3_borrow_out", 32'h200); expect_val("t3_borrow_pos", 32'h9);
        expect_val("t3_borrow", 32'h1); expect_val("t3_borrow_car", 32'h0);
        a_left = 1'b1; cyc(); a_left = 1'b0;
        repeat (3) cyc();
        observe(32'(a_out)); observe(32'(a_pos)); observe(32'(a_borrow)); observe(32'(a_carry));
        expect_val("t3_borrow_drop", 32'h0);
        cyc(); observe(32'(a_borrow));

        // Invalid load ignored, valid load during HOLD
        a_in = 10'b0000010000; cyc(); a_in = '0;
        expect_val("t4_lerr", 32'h1); expect_val("t4_lerr_out", 32'h10);
        a_in = 10'b0000000101; cyc();
        observe(32'(a_lerr)); observe(32'(a_out));
        expect_val("t4_lerr_drop", 32'h0); expect_val("t4_out_kept", 32'h10);
        a_in = '0; cyc();
        observe(32'(a_lerr)); observe(32'(a_out));
        expect_val("t4_hold_busy", 32'h1);
        a_right = 1'b1; cyc(); observe(32'(a_busy));
        expect_val("t4_hload_out", 32'h4); expect_val("t4_hload_busy", 32'h0);
        expect_val("t4_hload_pos", 32'h2);
        a_in = 10'b0000000100; cyc();
        observe(32'(a_out)); observe(32'(a_busy)); observe(32'(a_pos));
        a_in = '0; a_right = 1'b0;
        expect_val("t4_after_out", 32'h4);
        cyc(); observe(32'(a_out));

        // Both pulses together: no movement
        a_right = 1'b1; a_left = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_val("t5_both_busy", 32'h0); expect_val("t5_both_out", 32'h4);
            cyc(); observe(32'(a_busy)); observe(32'(a_out));
        end
        a_left = 1'b0;
        a_right = 1'b0; cyc();

        // Opposite pulse during right HOLD is ignored
        expect_val("t5_opp_out", 32'h8); expect_val("t5_opp_pos", 32'h3);
        expect_val("t5_opp_busy", 32'h0);
        a_right = 1'b1; cyc();
        a_left = 1'b1; cyc();
        a_right = 1'b0;
        repeat (3) cyc();
        observe(32'(a_out)); observe(32'(a_pos)); observe(32'(a_busy));
        a_left = 1'b0;

        // Twelve right steps around a 12-position ring (SETTLE_CYCLES=2)
        expect_val("t6_pos_init", 32'h0); observe(32'(c_pos));
        for (int s = 1; s <= 12; s++) begin
            expect_val("t6_pos", 32'(s % 12));
            c_right = 1'b1; cyc();
            if (c_carry) carry_cnt++;
            if (c_borrow) borrow_cnt++;
            c_right = 1'b0;
            repeat (4) begin
                cyc();
                if (c_carry) carry_cnt++;
                if (c_borrow) borrow_cnt++;
            end
            observe(32'(c_pos));
        end
        cyc();
        if (c_carry) carry_cnt++;
        expect_val("t6_out_final", 32'h1); observe(32'(c_out));
        expect_val("t6_carry_count", 32'h1); observe(32'(carry_cnt));
        expect_val("t6_borrow_count", 32'h0); observe(32'(borrow_cnt));

        checks++;
        assert (q_exp.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover: observed %0d queued expectations expected 0", q_exp.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
